// File: rtl/imem_loader.sv
// Byte-stream program loader for the 256x16 instruction memory: parses
// {count, N big-endian words, XOR checksum} and freezes the core while loading.
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_WR, S_CHK, S_FIN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_hi;
  logic [7:0]        r_xor;
  logic [TW-1:0]     r_tmo;

  logic              w_acc;
  logic              w_tmo;
  logic [ADDR_W-1:0] w_last_idx;

  // rx_ready is registered and already reflects the state, so it alone gates accept
  assign w_acc      = rx_valid && rx_ready;
  assign w_tmo      = (r_tmo == TW'(TIMEOUT));
  // count 0 wraps to all-ones, i.e. a full 2^ADDR_W word image
  assign w_last_idx = r_cnt - ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_hi      <= '0;
      r_xor     <= '0;
      r_tmo     <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_COUNT;
            done     <= 1'b0;
            err      <= 1'b0;
            r_xor    <= '0;
            r_idx    <= '0;
            r_tmo    <= '0;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
            rx_ready <= 1'b1;
          end
        end
        S_COUNT, S_HI, S_LO, S_CHK: begin
          if (w_acc) begin
            r_tmo <= '0;
            case (r_state)
              S_COUNT: begin
                r_cnt   <= ADDR_W'(rx_data);
                r_state <= S_HI;
              end
              S_HI: begin
                r_hi    <= rx_data;
                r_xor   <= r_xor ^ rx_data;
                r_state <= S_LO;
              end
              S_LO: begin
                r_xor     <= r_xor ^ rx_data;
                mem_we    <= 1'b1;
                mem_addr  <= r_idx;
                mem_wdata <= {r_hi, rx_data};
                rx_ready  <= 1'b0;
                r_state   <= S_WR;
              end
              S_CHK: begin
                if (rx_data == r_xor) begin
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                end else begin
                  err <= 1'b1;
                end
                busy     <= 1'b0;
                rx_ready <= 1'b0;
                r_state  <= S_FIN;
              end
              default: ;
            endcase
          end else if (w_tmo) begin
            // stalled host: abort, keep the core frozen, keep partial writes
            err      <= 1'b1;
            busy     <= 1'b0;
            rx_ready <= 1'b0;
            r_tmo    <= '0;
            r_state  <= S_FIN;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_WR: begin
          r_idx    <= r_idx + 1'b1;
          r_tmo    <= '0;
          rx_ready <= 1'b1;
          r_state  <= (r_idx == w_last_idx) ? S_CHK : S_HI;
        end
        S_FIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
